// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave with NUM_REGS word registers, byte strobes, read-only slices and per-register write pulses.
// Write and read channels run as independent two-state FSMs. Bad addresses and writes to read-only registers get SLVERR.
module axi4_lite_reg_bank #(
  parameter int                  ADDR_BIT_WIDTH = 6,
  parameter int                  DATA_BIT_WIDTH = 32,
  parameter int                  NUM_REGS       = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
  input  logic                               i_clk,
  input  logic                               i_sync_rst,
  input  logic [ADDR_BIT_WIDTH-1:0]          i_s_awaddr,
  input  logic [2:0]                         i_s_awprot,
  input  logic                               i_s_awvalid,
  output logic                               o_s_awready,
  input  logic [DATA_BIT_WIDTH-1:0]          i_s_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0]        i_s_wstrb,
  input  logic                               i_s_wvalid,
  output logic                               o_s_wready,
  output logic [1:0]                         o_s_bresp,
  output logic                               o_s_bvalid,
  input  logic                               i_s_bready,
  input  logic [ADDR_BIT_WIDTH-1:0]          i_s_araddr,
  input  logic [2:0]                         i_s_arprot,
  input  logic                               i_s_arvalid,
  output logic                               o_s_arready,
  output logic [DATA_BIT_WIDTH-1:0]          o_s_rdata,
  output logic [1:0]                         o_s_rresp,
  output logic                               o_s_rvalid,
  input  logic                               i_s_rready,
  input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0] i_ro_vals,
  output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] o_regs,
  output logic [NUM_REGS-1:0]                o_wr_pulse
);
  localparam int STRB_W = DATA_BIT_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_BIT_WIDTH - OFF_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic                      aw_got_q, w_got_q;
  logic [IDX_W-1:0]          aw_idx_q, wr_idx, ar_idx;
  logic [DATA_BIT_WIDTH-1:0] wdata_q, wr_data;
  logic [STRB_W-1:0]         wstrb_q, wr_strb;
  logic [1:0]                bresp_q, rresp_q, rd_resp_d;
  logic [DATA_BIT_WIDTH-1:0] rdata_q, rd_data_d;
  logic                      aw_hs, w_hs, ar_hs, wr_fire, wr_ok;
  logic                      unused_ok;

  logic [NUM_REGS-1:0][DATA_BIT_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                     wr_pulse_q, wr_pulse_d;

  assign unused_ok = ^{i_s_awprot, i_s_arprot, i_s_awaddr[OFF_W-1:0], i_s_araddr[OFF_W-1:0]};

  assign aw_hs   = i_s_awvalid & o_s_awready;
  assign w_hs    = i_s_wvalid & o_s_wready;
  assign ar_hs   = i_s_arvalid & o_s_arready;
  // Whichever of AW/W arrives second completes the write on that same edge.
  assign wr_fire = (wr_state_q == WR_IDLE) & (aw_got_q | aw_hs) & (w_got_q | w_hs);
  assign wr_idx  = aw_got_q ? aw_idx_q : i_s_awaddr[ADDR_BIT_WIDTH-1:OFF_W];
  assign wr_data = w_got_q ? wdata_q : i_s_wdata;
  assign wr_strb = w_got_q ? wstrb_q : i_s_wstrb;
  assign ar_idx  = i_s_araddr[ADDR_BIT_WIDTH-1:OFF_W];

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    case (wr_state_q)
      WR_IDLE: if (wr_fire) wr_state_d = WR_RESP;
      WR_RESP: if (i_s_bready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
    case (rd_state_q)
      RD_IDLE: if (ar_hs) rd_state_d = RD_RESP;
      RD_RESP: if (i_s_rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    o_s_awready = (wr_state_q == WR_IDLE) & ~aw_got_q;
    o_s_wready  = (wr_state_q == WR_IDLE) & ~w_got_q;
    o_s_bvalid  = (wr_state_q == WR_RESP);
    o_s_bresp   = bresp_q;
    o_s_arready = (rd_state_q == RD_IDLE);
    o_s_rvalid  = (rd_state_q == RD_RESP);
    o_s_rdata   = rdata_q;
    o_s_rresp   = rresp_q;
    o_wr_pulse  = wr_pulse_q;
  end

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    wr_ok      = 1'b0;
    rd_data_d  = '0;
    rd_resp_d  = RESP_SLVERR;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (wr_idx == IDX_W'(n) && !RO_MASK[n]) begin
        wr_ok = 1'b1;
        if (wr_fire) begin
          wr_pulse_d[n] = 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (wr_strb[k]) regs_d[n][8*k +: 8] = wr_data[8*k +: 8];
          end
        end
      end
      if (ar_idx == IDX_W'(n)) begin
        rd_resp_d = RESP_OKAY;
        rd_data_d = RO_MASK[n] ? i_ro_vals[n*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] : regs_q[n];
      end
    end
  end

  always_comb begin
    o_regs = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (!RO_MASK[n]) o_regs[n*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = regs_q[n];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      regs_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      if (aw_hs) begin
        aw_got_q <= 1'b1;
        aw_idx_q <= i_s_awaddr[ADDR_BIT_WIDTH-1:OFF_W];
      end
      if (w_hs) begin
        w_got_q <= 1'b1;
        wdata_q <= i_s_wdata;
        wstrb_q <= i_s_wstrb;
      end
      if (wr_fire) begin
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (ar_hs) begin
        rdata_q <= rd_data_d;
        rresp_q <= rd_resp_d;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
module tb_axi4_lite_reg_bank;
  localparam logic [7:0] RO = 8'h01;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [255:0] ro_vals, regs;
  logic [7:0]   pulse;

  logic [31:0] model_regs [8];
  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  axi4_lite_reg_bank #(.ADDR_BIT_WIDTH(6), .DATA_BIT_WIDTH(32), .NUM_REGS(8), .RO_MASK(RO)) dut (
    .i_clk(clk), .i_sync_rst(rst),
    .i_s_awaddr(awaddr), .i_s_awprot(awprot), .i_s_awvalid(awvalid), .o_s_awready(awready),
    .i_s_wdata(wdata), .i_s_wstrb(wstrb), .i_s_wvalid(wvalid), .o_s_wready(wready),
    .o_s_bresp(bresp), .o_s_bvalid(bvalid), .i_s_bready(bready),
    .i_s_araddr(araddr), .i_s_arprot(arprot), .i_s_arvalid(arvalid), .o_s_arready(arready),
    .o_s_rdata(rdata), .o_s_rresp(rresp), .o_s_rvalid(rvalid), .i_s_rready(rready),
    .i_ro_vals(ro_vals), .o_regs(regs), .o_wr_pulse(pulse)
  );

  // Reference model: plain register array with byte-merge writes.
  function automatic logic [255:0] exp_regs();
    logic [255:0] v = '0;
    for (int n = 0; n < 8; n++) if (!RO[n]) v[n*32 +: 32] = model_regs[n];
    return v;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [7:0] pv);
    pv = '0;
    if (idx < 8 && !RO[idx]) begin
      for (int k = 0; k < 4; k++) if (s[k]) model_regs[idx][8*k +: 8] = d[8*k +: 8];
      resp = 2'b00;
      pv[idx] = 1'b1;
    end else resp = 2'b10;
  endtask

  task automatic model_read(input int idx, output logic [31:0] d, output logic [1:0] resp);
    if (idx >= 8) begin d = '0; resp = 2'b10; end
    else if (RO[idx]) begin d = ro_vals[idx*32 +: 32]; resp = 2'b00; end
    else begin d = model_regs[idx]; resp = 2'b00; end
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output logic [7:0] pv, output int pcyc,
                           output int lat, output logic b_after, output bit tmo);
    bit aw_done = 0, w_done = 0, b_done = 0, aw_f, w_f, b_f;
    int fire_cyc = -1, bwait = 0;
    resp = 2'bxx; pv = '0; pcyc = 0; lat = -1; b_after = 1'bx; tmo = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (|pulse) pcyc++;
      pv |= pulse;
      if (bvalid && lat < 0) begin lat = c - fire_cyc; resp = bresp; end
      if (b_done) begin b_after = bvalid; tmo = 0; break; end
      awaddr = addr; wdata = d; wstrb = s;
      awvalid = !aw_done && c >= aw_dly;
      wvalid  = !w_done && c >= w_dly;
      bready  = bvalid && bwait >= b_dly;
      if (bvalid) bwait++;
      aw_f = awvalid && awready; w_f = wvalid && wready; b_f = bready && bvalid;
      @(posedge clk);
      if (aw_f) aw_done = 1;
      if (w_f) w_done = 1;
      if (b_f) b_done = 1;
      if ((aw_f || w_f) && aw_done && w_done && fire_cyc < 0) fire_cyc = c;
    end
    awvalid = 0; wvalid = 0; bready = 0;
  endtask

  task automatic axi_read(input logic [5:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] d, output logic [1:0] resp, output int lat, output bit tmo);
    bit ar_done = 0, r_done = 0, ar_f, r_f;
    int fire_cyc = -1, rwait = 0;
    d = 'x; resp = 2'bxx; lat = -1; tmo = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rvalid && lat < 0) begin lat = c - fire_cyc; d = rdata; resp = rresp; end
      if (r_done) begin tmo = 0; break; end
      araddr  = addr;
      arvalid = !ar_done && c >= ar_dly;
      rready  = rvalid && rwait >= r_dly;
      if (rvalid) rwait++;
      ar_f = arvalid && arready; r_f = rready && rvalid;
      @(posedge clk);
      if (ar_f) begin ar_done = 1; fire_cyc = c; end
      if (r_f) r_done = 1;
    end
    arvalid = 0; rready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    for (int n = 0; n < 8; n++) model_regs[n] = '0;
    cmp_cnt++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      err_cnt++; $display("FAIL reset_handshake: got %b exp 11100", {awready, wready, arready, bvalid, rvalid});
    end
    cmp_cnt++;
    if ({bresp, rresp, rdata, pulse} !== '0 || regs !== '0) begin
      err_cnt++; $display("FAIL reset_values: resp=%b/%b rdata=%h pulse=%b regs=%h", bresp, rresp, rdata, pulse, regs);
    end
  endtask

  task automatic check_write(input string name, input int idx, input logic [5:0] addr, input logic [31:0] d,
                             input logic [3:0] s, input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] resp, eresp; logic [7:0] pv, epv; int pcyc, lat; logic b_after; bit tmo;
    axi_write(addr, d, s, aw_dly, w_dly, b_dly, resp, pv, pcyc, lat, b_after, tmo);
    model_write(idx, d, s, eresp, epv);
    cmp_cnt++;
    if (tmo || resp !== eresp || lat !== 1 || b_after !== 1'b0) begin
      err_cnt++; $display("FAIL %s_bresp: tmo=%0d resp=%b exp %b lat=%0d exp 1 bvalid_after=%b", name, tmo, resp, eresp, lat, b_after);
    end
    cmp_cnt++;
    if (pv !== epv || pcyc !== (epv != 0 ? 1 : 0)) begin
      err_cnt++; $display("FAIL %s_pulse: got %b x%0d exp %b", name, pv, pcyc, epv);
    end
    cmp_cnt++;
    if (regs !== exp_regs()) begin
      err_cnt++; $display("FAIL %s_regs: got %h exp %h", name, regs, exp_regs());
    end
  endtask

  task automatic check_read(input string name, input int idx, input logic [5:0] addr, input int ar_dly, input int r_dly);
    logic [31:0] d, ed; logic [1:0] resp, eresp; int lat; bit tmo;
    model_read(idx, ed, eresp);
    axi_read(addr, ar_dly, r_dly, d, resp, lat, tmo);
    cmp_cnt++;
    if (tmo || d !== ed || resp !== eresp || lat !== 1) begin
      err_cnt++; $display("FAIL %s_read: tmo=%0d data=%h resp=%b lat=%0d exp data=%h resp=%b lat=1", name, tmo, d, resp, lat, ed, eresp);
    end
  endtask

  task automatic test_write_basic();
    check_write("aw_w_together", 1, 6'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check_write("w_before_aw", 2, 6'h08, 32'h11223344, 4'b0101, 2, 0, 0);
    cmp_cnt++;
    if (regs[2*32 +: 32] !== 32'h00220044) begin
      err_cnt++; $display("FAIL strobe_merge: got %h exp 00220044", regs[2*32 +: 32]);
    end
    check_read("readback", 1, 6'h04, 0, 0);
  endtask

  task automatic test_bad_access();
    check_read("oor", 8, 6'h20, 0, 0);
    check_write("oor", 8, 6'h20, 32'h12345678, 4'hF, 0, 0, 0);
    ro_vals = '0;
    ro_vals[31:0] = 32'hCAFE0001;
    check_read("ro", 0, 6'h00, 0, 0);
    check_write("ro", 0, 6'h00, 32'hFFFFFFFF, 4'hF, 0, 1, 0);
  endtask

  task automatic test_stall();
    logic [31:0] d = $urandom;
    @(negedge clk);
    awaddr = 6'h0C; wdata = d; wstrb = 4'hF; araddr = 6'h04;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge clk);
    model_regs[3] = d;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      awaddr = 6'h10; wdata = ~d; araddr = 6'h08;
      cmp_cnt++;
      if ({bvalid, bresp, rvalid, rresp} !== 6'b100100 || rdata !== model_regs[1]) begin
        err_cnt++; $display("FAIL stall_resp: bvalid=%b bresp=%b rvalid=%b rresp=%b rdata=%h exp rdata %h", bvalid, bresp, rvalid, rresp, rdata, model_regs[1]);
      end
      cmp_cnt++;
      if ({awready, wready, arready} !== 3'b000) begin
        err_cnt++; $display("FAIL stall_ready: got %b exp 000", {awready, wready, arready});
      end
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0; rready = 0;
    cmp_cnt++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111 || regs !== exp_regs()) begin
      err_cnt++; $display("FAIL stall_release: flags=%b regs=%h exp flags 00111 regs=%h", {bvalid, rvalid, awready, wready, arready}, regs, exp_regs());
    end
  endtask

  task automatic test_same_cycle_rw();
    logic [31:0] d = $urandom;
    logic [31:0] old = model_regs[5];
    @(negedge clk);
    awaddr = 6'h14; araddr = 6'h16; wdata = d; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_regs[5] = d;
    cmp_cnt++;
    if (!rvalid || !bvalid || rdata !== old || regs[5*32 +: 32] !== d) begin
      err_cnt++; $display("FAIL same_cycle_rw: rvalid=%b bvalid=%b rdata=%h exp %h reg5=%h exp %h", rvalid, bvalid, rdata, old, regs[5*32 +: 32], d);
    end
    bready = 1; rready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0; rready = 0;
  endtask

  task automatic test_back_to_back();
    int acc[$];
    @(negedge clk);
    araddr = 6'h08; arvalid = 1; rready = 1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 7) arvalid = 0;
      if (arvalid && arready) acc.push_back(c);
      @(posedge clk);
    end
    repeat (2) @(negedge clk);
    rready = 0;
    cmp_cnt++;
    if (acc.size() !== 4 || acc[0] !== 0 || acc[1] !== 2 || acc[2] !== 4 || acc[3] !== 6) begin
      err_cnt++; $display("FAIL back_to_back: accepts=%0d first=%0d second=%0d exp 4 accepts at 0,2,4,6", acc.size(), acc.size() > 0 ? acc[0] : -1, acc.size() > 1 ? acc[1] : -1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int idx = $urandom_range(0, 9);
      logic [5:0] addr = 6'(idx * 4 + $urandom_range(0, 3));
      for (int n = 0; n < 8; n++) ro_vals[n*32 +: 32] = $urandom;
      if ($urandom_range(0, 1) == 1)
        check_write("rand", idx, addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        check_read("rand", idx, addr, $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    awaddr = 6'h10; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    cmp_cnt++;
    if (bvalid !== 1'b1) begin
      err_cnt++; $display("FAIL rst_mid_pre: bvalid=%b exp 1", bvalid);
    end
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int n = 0; n < 8; n++) model_regs[n] = '0;
    cmp_cnt++;
    if ({bvalid, awready, wready, arready} !== 4'b0111 || regs !== '0 || pulse !== '0) begin
      err_cnt++; $display("FAIL rst_mid: flags=%b regs=%h pulse=%b exp 0111/0/0", {bvalid, awready, wready, arready}, regs, pulse);
    end
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (bvalid !== 1'b0) begin
      err_cnt++; $display("FAIL rst_mid_late: bvalid=%b exp 0", bvalid);
    end
  endtask

  initial begin
    rst = 1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; ro_vals = '0;
    test_reset();
    test_write_basic();
    test_bad_access();
    test_stall();
    test_same_cycle_rw();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
